// File: rtl/prm_edge_mask_engine.sv
// prm_edge_mask_engine
//   Table-driven obstacle check for the PRM roadmap. A quantised arm
//   configuration is compared against a programmable table of
//   sum-of-products cubes. Each cube carries an edge index, and every
//   matching cube sets that edge's bit in the result mask
//   (1 = edge blocked). One table entry is scanned per clock.
//
//   Optional feature macro: PRM_EDGE_HITCNT_EN. When defined, the module
//   gains the r_hits output, which counts the matching cubes per query.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   tbl_we/tbl_addr   cube table write: care mask, literal polarity and
//   tbl_care/tbl_val  target edge. Writes are accepted only while idle.
//   tbl_edge
//   len_we/len_wdata  active table length (saturates at DEPTH); idle only
//   tbl_err           one-cycle pulse when a table/length write is rejected
//   q_valid/q_ready   query handshake, q_data = quantised configuration
//   q_data
//   r_valid/r_ready   result handshake, r_mask = edge mask
//   r_mask
//   r_hits            (PRM_EDGE_HITCNT_EN only) matching cube count
module prm_edge_mask_engine #(
  parameter int IN_W    = 15,
  parameter int N_EDGES = 64,
  parameter int DEPTH   = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tbl_we,
  input  logic [$clog2(DEPTH)-1:0]     tbl_addr,
  input  logic [IN_W-1:0]              tbl_care,
  input  logic [IN_W-1:0]              tbl_val,
  input  logic [$clog2(N_EDGES)-1:0]   tbl_edge,
  input  logic                         len_we,
  input  logic [$clog2(DEPTH):0]       len_wdata,
  output logic                         tbl_err,
  input  logic                         q_valid,
  output logic                         q_ready,
  input  logic [IN_W-1:0]              q_data,
  output logic                         r_valid,
  input  logic                         r_ready,
  output logic [N_EDGES-1:0]           r_mask
`ifdef PRM_EDGE_HITCNT_EN
  ,
  output logic [$clog2(DEPTH):0]       r_hits
`endif
);

  localparam int EW      = $clog2(N_EDGES);
  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = 2 * IN_W + EW;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [IN_W-1:0]     q_reg;
  logic [AW:0]         tbl_len;
  logic [AW:0]         q_len;
  logic [AW:0]         rd_ptr;
  logic                rd_vld;
  logic [N_EDGES-1:0]  acc;

  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [ENTRY_W-1:0]  rd_data;

  logic [IN_W-1:0]     rd_care;
  logic [IN_W-1:0]     rd_val;
  logic [EW-1:0]       rd_edge;
  logic                cube_hit;
  logic [N_EDGES-1:0]  hit_vec;
  logic                issue;
  logic                accept;
  logic                idle;

  assign idle   = (state == IDLE);
  assign accept = idle && q_valid && q_ready;

  // A read is issued for every table index below the latched length.
  // rd_ptr keeps counting past the length so that the pipeline drains.
  assign issue  = (state == SCAN) && (rd_ptr < q_len);

  assign rd_care = rd_data[ENTRY_W-1 -: IN_W];
  assign rd_val  = rd_data[EW +: IN_W];
  assign rd_edge = rd_data[EW-1:0];

  // A cube matches when every literal it cares about equals the query bit.
  // A care mask of zero therefore matches every query.
  assign cube_hit = rd_vld && (((q_reg ^ rd_val) & rd_care) == '0);

  // Decode the edge index of the current cube to a one-hot vector.
  // An index with no corresponding mask bit decodes to all zeros, so it
  // has no effect on the result.
  always_comb begin
    hit_vec = '0;
    for (int e = 0; e < N_EDGES; e++) begin
      if (rd_edge == EW'(e)) begin
        hit_vec[e] = cube_hit;
      end
    end
  end

  // Cube table storage. This RAM has no reset, so its contents survive
  // a reset. Writes are accepted only in IDLE. Reads are registered, so
  // a cube is compared one cycle after its read is issued.
  always_ff @(posedge clk) begin
    if (tbl_we && idle) begin
      mem[tbl_addr] <= {tbl_care, tbl_val, tbl_edge};
    end
    if (issue) begin
      rd_data <= mem[rd_ptr[AW-1:0]];
    end
  end

  // Control FSM.
  // In SCAN, each cycle issues a read and folds the previous cube into
  // acc. The FSM moves to DONE when rd_ptr reaches q_len+1, which is the
  // first cycle after the last compare. Outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      q_ready <= 1'b1;
      r_valid <= 1'b0;
      r_mask  <= '0;
      tbl_err <= 1'b0;
      tbl_len <= '0;
      q_reg   <= '0;
      q_len   <= '0;
      rd_ptr  <= '0;
      rd_vld  <= 1'b0;
      acc     <= '0;
    end else begin
      tbl_err <= (tbl_we || len_we) && !idle;
      rd_vld  <= issue;

      if (len_we && idle) begin
        tbl_len <= (len_wdata > DEPTH_L) ? DEPTH_L : len_wdata;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            q_reg   <= q_data;
            q_len   <= tbl_len;
            acc     <= '0;
            rd_ptr  <= '0;
            q_ready <= 1'b0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          rd_ptr <= rd_ptr + ONE_L;
          acc    <= acc | hit_vec;
          if (rd_ptr == q_len + ONE_L) begin
            r_mask  <= acc;
            r_valid <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            q_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          q_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PRM_EDGE_HITCNT_EN
  // Counts matching cubes for the current query. The count is cleared
  // on accept and saturates at DEPTH. It is stable while r_valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hits <= '0;
    end else if (accept) begin
      r_hits <= '0;
    end else if ((state == SCAN) && cube_hit && (r_hits != DEPTH_L)) begin
      r_hits <= r_hits + ONE_L;
    end
  end
`else
  // This build has no hit counter.
`endif

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// tb_prm_edge_mask_engine
//   Directed bench for prm_edge_mask_engine with IN_W=15, N_EDGES=4,
//   DEPTH=16. Expected masks, latencies and hit counts are worked out
//   by hand from the table contents. Define PRM_EDGE_HITCNT_EN to also
//   check r_hits.
module tb_prm_edge_mask_engine;

  localparam int IN_W    = 15;
  localparam int N_EDGES = 4;
  localparam int DEPTH   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tbl_we = 1'b0;
  logic [3:0]  tbl_addr = '0;
  logic [14:0] tbl_care = '0;
  logic [14:0] tbl_val = '0;
  logic [1:0]  tbl_edge = '0;
  logic        len_we = 1'b0;
  logic [4:0]  len_wdata = '0;
  logic        tbl_err;
  logic        q_valid = 1'b0;
  logic        q_ready;
  logic [14:0] q_data = '0;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic [3:0]  r_mask;
`ifdef PRM_EDGE_HITCNT_EN
  logic [4:0]  r_hits;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;

  prm_edge_mask_engine #(
    .IN_W(IN_W), .N_EDGES(N_EDGES), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_care(tbl_care),
    .tbl_val(tbl_val), .tbl_edge(tbl_edge),
    .len_we(len_we), .len_wdata(len_wdata), .tbl_err(tbl_err),
    .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_mask(r_mask)
`ifdef PRM_EDGE_HITCNT_EN
    , .r_hits(r_hits)
`endif
  );

  // Advances one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_cube(input int addr, input logic [14:0] care,
                            input logic [14:0] val, input logic [1:0] e);
    tbl_we   = 1'b1;
    tbl_addr = 4'(addr);
    tbl_care = care;
    tbl_val  = val;
    tbl_edge = e;
    tick();
    tbl_we   = 1'b0;
  endtask

  task automatic write_len(input int n);
    len_we    = 1'b1;
    len_wdata = 5'(n);
    tick();
    len_we    = 1'b0;
  endtask

  task automatic start_query(input logic [14:0] q, input string tag);
    q_valid = 1'b1;
    q_data  = q;
    tick();
    q_valid = 1'b0;
    acc_cyc = cyc;
    check_output({tag, "_qready_low"}, 64'(q_ready), 64'd0);
  endtask

  // Waits for r_valid, giving up after 100 cycles, and checks the latency
  // counted from the accept edge.
  task automatic wait_result(input int exp_lat, input string tag);
    while (!r_valid && (cyc - acc_cyc) < 100) tick();
    check_output({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(exp_lat));
  endtask

  // Checks the result, holds it under back-pressure for 'hold' cycles,
  // then completes the handshake.
  task automatic finish_result(input logic [3:0] exp_mask, input int exp_hits,
                               input int hold, input string tag);
    check_output({tag, "_mask"}, 64'(r_mask), 64'(exp_mask));
`ifdef PRM_EDGE_HITCNT_EN
    check_output({tag, "_hits"}, 64'(r_hits), 64'(exp_hits));
`endif
    for (int i = 0; i < hold; i++) begin
      tick();
      check_output({tag, "_hold_mask"}, 64'(r_mask), 64'(exp_mask));
      check_output({tag, "_hold_qready"}, 64'(q_ready), 64'd0);
      check_output({tag, "_hold_rvalid"}, 64'(r_valid), 64'd1);
    end
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    check_output({tag, "_post_qready"}, 64'(q_ready), 64'd1);
    check_output({tag, "_post_rvalid"}, 64'(r_valid), 64'd0);
  endtask

  task automatic apply_stimulus(input logic [14:0] q, input int len,
                                input logic [3:0] exp_mask, input int exp_hits,
                                input int hold, input string tag);
    start_query(q, tag);
    wait_result(len + 2, tag);
    finish_result(exp_mask, exp_hits, hold, tag);
  endtask

  initial begin
    int high_cnt;
    $display("[TB] start");

    // 1: reset state, then an empty-table query
    repeat (3) tick();
    check_output("rst_qready", 64'(q_ready), 64'd1);
    check_output("rst_rvalid", 64'(r_valid), 64'd0);
    check_output("rst_rmask", 64'(r_mask), 64'd0);
    check_output("rst_tblerr", 64'(tbl_err), 64'd0);
    rst_n = 1'b1;
    tick();
    apply_stimulus(15'h1234, 0, 4'b0000, 0, 0, "len0");

    // 2: exact-match cube
    write_cube(0, 15'h7FFF, 15'h1234, 2'd2);
    write_len(1);
    apply_stimulus(15'h1234, 1, 4'b0100, 1, 0, "exact_hit");
    apply_stimulus(15'h1235, 1, 4'b0000, 0, 0, "exact_miss");

    // 3: don't-care bits, an always-true cube, and OR onto one edge
    write_cube(0, 15'h0003, 15'h0001, 2'd1);
    write_cube(1, 15'h0000, 15'h0000, 2'd3);
    write_cube(2, 15'h0001, 15'h0000, 2'd1);
    write_len(3);
    apply_stimulus(15'h7FFD, 3, 4'b1010, 2, 0, "dc_or");
    apply_stimulus(15'h0003, 3, 4'b1000, 1, 0, "dc_only_true");

    // 4: back-pressure holds the result for 10 cycles
    apply_stimulus(15'h7FFD, 3, 4'b1010, 2, 10, "bp");

    // 5: writes while busy are rejected with a one-cycle tbl_err pulse
    start_query(15'h7FFD, "busy");
    tbl_we = 1'b1; tbl_addr = 4'd0; tbl_care = 15'h7FFF;
    tbl_val = 15'h0000; tbl_edge = 2'd0;
    tick();
    tbl_we = 1'b0;
    check_output("busy_tbl_err_pulse", 64'(tbl_err), 64'd1);
    tick();
    check_output("busy_tbl_err_clear", 64'(tbl_err), 64'd0);
    len_we = 1'b1; len_wdata = 5'd1;
    tick();
    len_we = 1'b0;
    check_output("busy_len_err_pulse", 64'(tbl_err), 64'd1);
    tick();
    check_output("busy_len_err_clear", 64'(tbl_err), 64'd0);
    wait_result(5, "busy");
    finish_result(4'b1010, 2, 0, "busy");
    apply_stimulus(15'h0003, 3, 4'b1000, 1, 0, "busy_len_kept");

    // Fill entries 3..15: 3..14 match only q=0 on edge 0, and 15 is always
    // true on edge 0. The last table write and a saturating length write
    // happen in the same cycle.
    for (int a = 3; a < 15; a++) write_cube(a, 15'h7FFF, 15'h0000, 2'd0);
    tbl_we = 1'b1; tbl_addr = 4'd15; tbl_care = 15'h0000;
    tbl_val = 15'h0000; tbl_edge = 2'd0;
    len_we = 1'b1; len_wdata = 5'd31;
    tick();
    tbl_we = 1'b0; len_we = 1'b0;
    check_output("idle_write_no_err", 64'(tbl_err), 64'd0);
    apply_stimulus(15'h7FFD, 16, 4'b1011, 3, 0, "len_sat");

    // 6: reset during SCAN aborts the query; the RAM survives, tbl_len clears
    start_query(15'h7FFD, "midrst");
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_output("midrst_rvalid", 64'(r_valid), 64'd0);
    check_output("midrst_qready", 64'(q_ready), 64'd1);
    check_output("midrst_rmask", 64'(r_mask), 64'd0);
    tick();
    rst_n = 1'b1;
    high_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (r_valid) high_cnt++;
    end
    check_output("midrst_no_result", 64'(high_cnt), 64'd0);
    apply_stimulus(15'h1234, 0, 4'b0000, 0, 0, "postrst_len0");
    write_len(3);
    apply_stimulus(15'h7FFD, 3, 4'b1010, 2, 0, "postrst_ram3");
    write_len(16);
    apply_stimulus(15'h7FFD, 16, 4'b1011, 3, 0, "postrst_ram16");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
